// File: rtl/sm_debug_ctrl_pkg.sv
// Shared types and constants for the board debug sequencer.
package sm_debug_ctrl_pkg;

   localparam int unsigned STEPCNT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_STEP     = 2'd1,
      ST_WAIT_REL = 2'd2
   } step_state_t;

   function automatic logic [STEPCNT_W-1:0] sat_inc(input logic [STEPCNT_W-1:0] v);
      return (v == '1) ? v : v + STEPCNT_W'(1);
   endfunction

endpackage

// File: rtl/sm_debug_ctrl_if.sv
// Board-pin / sm_top signal bundle seen by the debug sequencer.
interface sm_debug_ctrl_if;
   import sm_debug_ctrl_pkg::*;

   logic                 btnStep_n;
   logic                 runMode;
   logic                 scanMode;
   logic [4:0]           regAddrSw;
   logic [31:0]          regData;
   logic                 clkEnable;
   logic [4:0]           regAddr;
   logic [31:0]          dispData;
   logic [4:0]           dispAddr;
   logic [STEPCNT_W-1:0] stepCount;

   modport master (
      output btnStep_n, runMode, scanMode, regAddrSw, regData,
      input  clkEnable, regAddr, dispData, dispAddr, stepCount
   );

   modport slave (
      input  btnStep_n, runMode, scanMode, regAddrSw, regData,
      output clkEnable, regAddr, dispData, dispAddr, stepCount
   );

endinterface

// File: rtl/sm_debug_ctrl_debounce.sv
// Pushbutton synchronizer and debouncer; emits a 1-cycle pulse on an accepted press.
module sm_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_btn_n,
   output logic o_level,
   output logic o_press
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

   logic [1:0]    r_sync;
   logic [CW-1:0] r_cnt;
   logic          r_level;
   logic          r_press;
   logic          w_sample;
   logic          w_accept;

   assign w_sample = ~r_sync[1];
   // Counts consecutive samples that disagree with the accepted level; any sample
   // matching the old level restarts the run.
   assign w_accept = (w_sample != r_level) && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync  <= '1;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_press <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], i_btn_n};
         r_press <= w_accept & w_sample;
         if (w_sample == r_level) begin
            r_cnt <= '0;
         end else if (w_accept) begin
            r_cnt   <= '0;
            r_level <= w_sample;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_level = r_level;
   assign o_press = r_press;

endmodule

// File: rtl/sm_debug_ctrl.sv
// Debug sequencer: single-step/free-run clock enable, register scan and display latch.
module sm_debug_ctrl
   import sm_debug_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned STEP_CYCLES     = 1,
   parameter int unsigned SCAN_PERIOD     = 25000000,
   parameter int unsigned SCAN_FIRST      = 1,
   parameter int unsigned SCAN_LAST       = 31
) (
   input  logic           clk,
   input  logic           rst_n,
   sm_debug_ctrl_if.slave bus
);

   localparam int unsigned SCW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam int unsigned PCW = $clog2(SCAN_PERIOD);

   step_state_t          r_state, w_state_nxt;
   logic [SCW-1:0]       r_cnt, w_cnt_nxt;
   logic [STEPCNT_W-1:0] r_steps;
   logic                 w_inc;
   logic                 r_run;
   logic                 w_level;
   logic                 w_press;

   logic [PCW-1:0]       r_period;
   logic [4:0]           r_addr;
   logic                 r_scan_prev;
   logic [31:0]          r_disp_data;
   logic [4:0]           r_disp_addr;

   sm_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_btn_n (bus.btnStep_n),
      .o_level (w_level),
      .o_press (w_press)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_steps <= '0;
         r_run   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_run   <= bus.runMode;
         if (w_inc) r_steps <= sat_inc(r_steps);
      end
   end

   // runMode is checked first so a mode change always beats a press in the same cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_inc       = 1'b0;
      if (bus.runMode) begin
         w_state_nxt = ST_IDLE;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_press) begin
                  w_state_nxt = ST_STEP;
                  w_cnt_nxt   = SCW'(STEP_CYCLES - 1);
               end
            end
            ST_STEP: begin
               if (r_cnt == '0) begin
                  w_state_nxt = ST_WAIT_REL;
                  w_inc       = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt - SCW'(1);
               end
            end
            ST_WAIT_REL: begin
               if (!w_level) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_period    <= '0;
         r_addr      <= '0;
         r_scan_prev <= 1'b0;
         r_disp_data <= '0;
         r_disp_addr <= '0;
      end else begin
         r_scan_prev <= bus.scanMode;
         r_disp_data <= bus.regData;
         r_disp_addr <= r_addr;
         if (!bus.scanMode) begin
            r_addr <= bus.regAddrSw;
         end else if (!r_scan_prev) begin
            r_addr   <= 5'(SCAN_FIRST);
            r_period <= '0;
         end else if (r_period == PCW'(SCAN_PERIOD - 1)) begin
            r_period <= '0;
            r_addr   <= (r_addr == 5'(SCAN_LAST)) ? 5'(SCAN_FIRST) : r_addr + 5'd1;
         end else begin
            r_period <= r_period + PCW'(1);
         end
      end
   end

   assign bus.clkEnable = r_run | (r_state == ST_STEP);
   assign bus.regAddr   = r_addr;
   assign bus.dispData  = r_disp_data;
   assign bus.dispAddr  = r_disp_addr;
   assign bus.stepCount = r_steps;

endmodule

// File: tb/tb_sm_debug_ctrl.sv
// Scoreboard bench for sm_debug_ctrl with a model register file regData = addr*0x1111.
module tb_sm_debug_ctrl;
   import sm_debug_ctrl_pkg::*;

   localparam int unsigned DEB   = 4;
   localparam int unsigned STEPC = 3;
   localparam int unsigned SPER  = 5;
   localparam int unsigned SF    = 1;
   localparam int unsigned SL    = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sm_debug_ctrl_if bus();

   sm_debug_ctrl #(
      .DEBOUNCE_CYCLES(DEB),
      .STEP_CYCLES    (STEPC),
      .SCAN_PERIOD    (SPER),
      .SCAN_FIRST     (SF),
      .SCAN_LAST      (SL)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   assign bus.regData = 32'(bus.regAddr) * 32'h1111;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   int unsigned step_q[$];
   logic [4:0]  addr_q[$];

   int unsigned run_len   = 0;
   bit          run_mixed = 1'b0;
   logic [4:0]  prev_addr = '0;
   bit          prev_ok   = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         run_len   = 0;
         run_mixed = 1'b0;
         prev_ok   = 1'b0;
      end else begin
         if (bus.clkEnable) begin
            run_len++;
            if (bus.runMode) run_mixed = 1'b1;
         end else if (run_len != 0) begin
            if (!run_mixed) begin
               if (step_q.size() != 0) check_val("step_len", run_len, step_q.pop_front());
               else                    check_val("unexpected_step", run_len, 0);
            end
            run_len   = 0;
            run_mixed = 1'b0;
         end
         if (addr_q.size() != 0) check_val("scan_addr", bus.regAddr, addr_q.pop_front());
         if (prev_ok) begin
            check_val("disp_addr", bus.dispAddr, prev_addr);
            check_val("disp_data", bus.dispData, 32'(prev_addr) * 32'h1111);
         end
         prev_addr = bus.regAddr;
         prev_ok   = 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_enable();
      bit seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (bus.clkEnable) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check_val("enable_timeout", 0, 1);
   endtask

   task automatic press_bouncy();
      bus.btnStep_n = 1'b0; tick();
      bus.btnStep_n = 1'b1; tick();
      bus.btnStep_n = 1'b0;
      repeat (20) tick();
      bus.btnStep_n = 1'b1;
      repeat (20) tick();
   endtask

   task automatic check_reset_values();
      check_val("rst_clkEnable", bus.clkEnable, 0);
      check_val("rst_regAddr",   bus.regAddr,   0);
      check_val("rst_dispData",  bus.dispData,  0);
      check_val("rst_dispAddr",  bus.dispAddr,  0);
      check_val("rst_stepCount", bus.stepCount, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int unsigned cnt;
      int unsigned exp_steps;

      bus.btnStep_n = 1'b1;
      bus.runMode   = 1'b0;
      bus.scanMode  = 1'b0;
      bus.regAddrSw = 5'd0;
      exp_steps     = 0;
      repeat (3) tick();
      check_reset_values();
      rst_n = 1'b1;

      // idle, no press
      cnt = 0;
      repeat (100) begin
         tick();
         if (bus.clkEnable) cnt++;
      end
      check_val("idle_enable_cycles", cnt, 0);
      check_val("idle_stepCount", bus.stepCount, 0);

      // two bouncy presses
      step_q.push_back(STEPC);
      press_bouncy();
      exp_steps++;
      check_val("step1_count", bus.stepCount, exp_steps);
      step_q.push_back(STEPC);
      press_bouncy();
      exp_steps++;
      check_val("step2_count", bus.stepCount, exp_steps);
      check_val("step_q_drained", step_q.size(), 0);

      // bounces shorter than the debounce window
      repeat (3) begin
         bus.btnStep_n = 1'b0; repeat (3) tick();
         bus.btnStep_n = 1'b1; repeat (2) tick();
      end
      repeat (30) tick();
      check_val("short_bounce_count", bus.stepCount, exp_steps);

      // manual address with one-cycle latency, display one cycle later
      bus.regAddrSw = 5'd5;
      tick();
      check_val("manual_addr", bus.regAddr, 5);
      tick();
      check_val("manual_dispAddr", bus.dispAddr, 5);
      check_val("manual_dispData", bus.dispData, 32'h5555);

      // run mode entered during a step
      bus.btnStep_n = 1'b0;
      wait_enable();
      bus.runMode = 1'b1;
      cnt = 0;
      repeat (10) begin
         tick();
         if (!bus.clkEnable) cnt++;
      end
      check_val("run_enable_gaps", cnt, 0);
      check_val("run_stepCount", bus.stepCount, exp_steps);
      bus.runMode = 1'b0;
      tick();
      check_val("run_exit_enable", bus.clkEnable, 0);
      cnt = 0;
      repeat (10) begin
         tick();
         if (bus.clkEnable) cnt++;
      end
      check_val("held_no_repeat", cnt, 0);
      bus.btnStep_n = 1'b1;
      repeat (20) tick();
      check_val("run_stepCount_after", bus.stepCount, exp_steps);

      // register scan
      bus.scanMode = 1'b1;
      tick();
      for (int k = 0; k < 20; k++) addr_q.push_back(5'(SF + (k / SPER) % (SL - SF + 1)));
      repeat (20) tick();
      check_val("scan_q_drained", addr_q.size(), 0);
      bus.scanMode  = 1'b0;
      bus.regAddrSw = 5'd9;
      tick();
      check_val("scan_exit_addr", bus.regAddr, 9);

      // reset mid-step
      bus.btnStep_n = 1'b0;
      wait_enable();
      rst_n         = 1'b0;
      bus.btnStep_n = 1'b1;
      #1;
      check_reset_values();
      tick();
      rst_n     = 1'b1;
      exp_steps = 0;
      repeat (20) tick();
      check_val("post_reset_count", bus.stepCount, 0);
      step_q.push_back(STEPC);
      press_bouncy();
      exp_steps++;
      check_val("post_reset_step", bus.stepCount, exp_steps);
      check_val("final_step_q", step_q.size(), 0);
      check_val("final_addr_q", addr_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
